uart_tx_feeder: RTL and testbench

Byte-buffering transmit feeder that sits directly upstream of a UART transmitter channel inside `UART_System`. It accepts bytes from a producer over a valid/ready handshake, stores them in a FIFO, and drives the UART's `dataIn_uartN` / `idle_uartN` pair one frame at a time. Inter-frame spacing is enforced by an internal counter, so the producer never has to track UART timing.

---
 rtl/uart_tx_feeder_if.sv | 11 +
 rtl/uart_tx_feeder.sv | 107 ++++++++++
 tb/tb_uart_tx_feeder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Producer-side byte handshake into the UART transmit feeder.
interface uart_tx_feeder_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes in a FIFO and presents them to a UART channel one frame
// at a time, holding idle low per frame and enforcing a minimum inter-frame gap.
module uart_tx_feeder #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FRAME_CYCLES = 11,
  parameter int unsigned GAP_CYCLES   = 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  prod,
  output logic [7:0]       dataIn,
  output logic             idle,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned TMR_MAX = ((FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES) - 1;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [7:0]       mem [DEPTH];
  logic             push, pop;

  assign prod.in_ready = (count < CNT_W'(DEPTH));
  assign push          = prod.in_valid && prod.in_ready;
  assign idle          = (state != SEND);
  assign busy          = (state != IDLE) || (count != '0);

  // Frame/gap sequencing; a pop only ever accompanies entry into SEND.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          tmr_nxt   = TMR_W'(FRAME_CYCLES - 1);
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tmr == '0) begin
          tmr_nxt   = TMR_W'(GAP_CYCLES - 1);
          state_nxt = GAP;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      GAP: begin
        if (tmr == '0) begin
          if (count != '0) begin
            pop       = 1'b1;
            tmr_nxt   = TMR_W'(FRAME_CYCLES - 1);
            state_nxt = SEND;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointers, occupancy and the presented byte; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tmr    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dataIn <= 8'h00;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        dataIn <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count guards every read.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= prod.in_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table, directed corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  localparam int F     = 11;
  localparam int G     = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataIn;
  logic       idle, busy;
  logic [3:0] count;

  uart_tx_feeder_if ifc ();

  uart_tx_feeder #(.DEPTH(DEPTH), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .prod(ifc), .dataIn(dataIn), .idle(idle), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: queue contents and the edge at which the latest frame started.
  logic [7:0] m_q[$];
  int         m_last = -1000;
  logic [7:0] m_data = 8'h00;

  // Observation of the idle/dataIn waveform.
  logic       prev_idle = 1'b1;
  int         low_len = 0, high_len = 0, peak = 0;
  bit         saw_not_ready = 0;
  logic [7:0] tx_log[$];
  int         low_q[$], gap_q[$];

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       e_idle;
    logic [7:0] e_data;
    logic [3:0] e_count;
    logic       e_busy;
    logic       e_ready;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    int pre;
    if (r) begin
      m_q.delete();
      m_last = -1000;
      m_data = 8'h00;
    end else begin
      pre = m_q.size();
      if (pre != 0 && cyc >= m_last + F + G) begin
        m_data = m_q.pop_front();
        m_last = cyc;
      end
      if (v && pre < DEPTH) m_q.push_back(d);
    end
  endtask

  task automatic clear_mon();
    tx_log.delete(); low_q.delete(); gap_q.delete();
    peak = 0; saw_not_ready = 0;
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic e_idle;
    reset = r; ifc.in_valid = v; ifc.in_data = d;
    @(posedge clk);
    model_edge(r, v, d);
    @(negedge clk);
    e_idle = !(m_last <= cyc && cyc < m_last + F);
    chk("model_idle", idle, e_idle);
    chk("model_dataIn", dataIn, m_data);
    chk("model_count", count, m_q.size());
    chk("model_in_ready", ifc.in_ready, m_q.size() < DEPTH);
    chk("model_busy", busy, (cyc < m_last + F + G) || m_q.size() != 0);
    if (!idle) begin
      if (prev_idle) begin tx_log.push_back(dataIn); gap_q.push_back(high_len); low_len = 0; end
      low_len++;
    end else begin
      if (!prev_idle) begin low_q.push_back(low_len); high_len = 0; end
      high_len++;
    end
    prev_idle = idle;
    if (int'(count) > peak) peak = int'(count);
    if (!ifc.in_ready) saw_not_ready = 1;
    cyc++;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (busy && k < max) begin step(0, 0, 8'h00); k++; end
    chk("drain_timeout", busy, 0);
  endtask

  initial begin
    logic [7:0] exp3[3];
    logic [7:0] d;
    logic       rb;
    int         k, dens;

    ifc.in_valid = 1'b1; ifc.in_data = 8'hFF;

    // Reset with a pending offer: nothing may be pushed.
    step(1, 1, 8'hFF);
    step(1, 1, 8'hFF);
    chk("rst_idle", idle, 1); chk("rst_dataIn", dataIn, 8'h00); chk("rst_count", count, 0);
    chk("rst_in_ready", ifc.in_ready, 1); chk("rst_busy", busy, 0);
    step(0, 0, 8'h00);

    // Single-byte frame vectors.
    tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b1, 8'h00, 4'd1, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b1};
    for (int i = 2; i <= 11; i++) tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 4'd0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b1};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d);
      chk("vec_idle", idle, tbl[i].e_idle);
      chk("vec_dataIn", dataIn, tbl[i].e_data);
      chk("vec_count", count, tbl[i].e_count);
      chk("vec_busy", busy, tbl[i].e_busy);
      chk("vec_in_ready", ifc.in_ready, tbl[i].e_ready);
    end

    // Burst of three back-to-back frames.
    clear_mon();
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(0, 1, exp3[i]);
    wait_drain(100);
    chk("burst_frames", tx_log.size(), 3);
    chk("burst_peak", peak, 2);
    for (int i = 0; i < 3; i++) begin
      chk("burst_data", tx_log[i], exp3[i]);
      chk("burst_low_len", low_q[i], F);
    end
    chk("burst_gap1", gap_q[1], G);
    chk("burst_gap2", gap_q[2], G);

    // Fill to full while holding the offer; data advances only when accepted.
    clear_mon();
    d = 8'h40;
    for (int i = 0; i < 40; i++) begin
      rb = ifc.in_ready;
      step(0, 1, d);
      if (rb) d++;
    end
    wait_drain(300);
    chk("full_peak", peak, DEPTH);
    chk("full_not_ready", saw_not_ready, 1);
    chk("full_frames", tx_log.size(), int'(d) - 'h40);
    for (int i = 0; i < tx_log.size(); i++) chk("full_order", tx_log[i], 8'(8'h40 + i));

    // Push on the GAP->SEND edge with three queued: occupancy unchanged.
    clear_mon();
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h51 + i));
    k = 0;
    while (!idle && k < 20) begin step(0, 0, 8'h00); k++; end
    chk("simul_wait", idle, 1);
    for (int i = 1; i < G; i++) step(0, 0, 8'h00);
    chk("simul_count_before", count, 3);
    step(0, 1, 8'h55);
    chk("simul_count", count, 3);
    wait_drain(150);
    chk("simul_frames", tx_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("simul_order", tx_log[i], 8'(8'h51 + i));

    // Reset during the fifth SEND cycle with four bytes queued.
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h61 + i));
    chk("midrst_queued", count, 4);
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    chk("midrst_idle", idle, 1);
    chk("midrst_count", count, 0);
    clear_mon();
    for (int i = 0; i < 30; i++) step(0, 0, 8'h00);
    chk("midrst_no_frames", tx_log.size(), 0);

    // Randomized traffic with varying offer density and rare resets.
    dens = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) dens = $urandom_range(5, 100);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < dens, 8'($urandom));
    end
    wait_drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
